// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output in_valid, a, b, c_in, sub, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                    output in_ready, out_valid, sum, c_out);
`else
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out);
`endif

endinterface

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit ripple adder slice with a chained carry.
module nibble_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic carry;

    // NOTE: blocking assignments here are intentional; carry must ripple bit to bit within one evaluation.
    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle through a single 4-bit slice.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module nibble_serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;

    logic [NIB_W-1:0] slice_s;
    logic             slice_co;

    nibble_adder_slice u_slice (
        .a  (a_q[NIB_W-1:0]),
        .b  (b_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // NOTE: every _d starts as its _q so no branch leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
`else
                    b_d     = bus.b;
                    carry_d = bus.c_in;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New nibble enters at the top so the LSB nibble ends up at the bottom.
                sum_d   = (sum_q >> NIB_W) | (WIDTH'(slice_s) << (WIDTH - NIB_W));
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    c_out_d = slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomised and directed bench for nibble_serial_adder_ctrl against a plain-arithmetic model.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // {c_out, sum} as whole-number arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        return r;
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 50);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
        checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b want 0", bus.c_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [2] = '{16'h1234, 16'hFFFF};
        logic [WIDTH-1:0] tb [2] = '{16'h1111, 16'h0001};
        logic [WIDTH-1:0] es [2] = '{16'h2345, 16'h0000};
        logic             ec [2] = '{1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], 1'b0);
            wait_done(lat);
            checks++; if (lat != NIB) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NIB); end
            checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum: got %h want %h", i, bus.sum, es[i]); end
            checks++; if (bus.c_out !== ec[i]) begin errors++; $display("FAIL dir%0d_c_out: got %b want %b", i, bus.c_out, ec[i]); end
            consume();
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL dir%0d_release: in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        start_op(16'h00FF, 16'h0000, 1'b1);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.c_in     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(lat);
        checks++; if (lat + 2 != NIB) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat + 2, NIB); end
        checks++; if (bus.sum !== 16'h0100) begin errors++; $display("FAIL ign_sum: got %h want 0100", bus.sum); end
        checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL ign_c_out: got %b want 0", bus.c_out); end
        consume();
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL ign_no_recapture: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'hAB00, 16'h00CD, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 16'hABCD || bus.c_out !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b sum=%h c_out=%b in_ready=%b want 1/abcd/0/0",
                         i, bus.out_valid, bus.sum, bus.c_out, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        consume();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit seen_valid = 1'b0;
        start_op(16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.c_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_values: in_ready=%b out_valid=%b sum=%h c_out=%b want 1/0/0000/0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.c_out);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid) begin errors++; $display("FAIL mid_reset_no_valid: out_valid seen=1 want 0"); end
        start_op(16'h0001, 16'h0002, 1'b0);
        wait_done(lat);
        checks++; if (bus.sum !== 16'h0003 || bus.c_out !== 1'b0) begin
            errors++; $display("FAIL mid_reset_followup: sum=%h c_out=%b want 0003/0", bus.sum, bus.c_out);
        end
        consume();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             cin;
        logic [WIDTH:0]   exp;
        int lat;
        for (int i = 0; i < 25; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom_range(0, 1));
            exp = model(a, b, cin, 1'b0);
            start_op(a, b, cin);
            wait_done(lat);
            checks++;
            if (lat != NIB || {bus.c_out, bus.sum} !== exp) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h cin=%b got lat=%0d c_out=%b sum=%h want lat=%0d c_out=%b sum=%h",
                         i, a, b, cin, lat, bus.c_out, bus.sum, NIB, exp[WIDTH], exp[WIDTH-1:0]);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] ta [2] = '{16'h0005, 16'h0007};
        logic [WIDTH-1:0] tb [2] = '{16'h0007, 16'h0005};
        logic [WIDTH:0]   exp;
        int lat;
        for (int i = 0; i < 2; i++) begin
            exp     = model(ta[i], tb[i], 1'b0, 1'b1);
            bus.sub = 1'b1;
            start_op(ta[i], tb[i], 1'b0);
            bus.sub = 1'b0;
            wait_done(lat);
            checks++;
            if ({bus.c_out, bus.sum} !== exp) begin
                errors++;
                $display("FAIL sub%0d: got c_out=%b sum=%h want c_out=%b sum=%h",
                         i, bus.c_out, bus.sum, exp[WIDTH], exp[WIDTH-1:0]);
            end
            consume();
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        test_reset();
        test_directed();
        test_ignore_in_valid();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that reuses one 4-bit ripple adder slice to add WIDTH-bit operands over WIDTH/4 clock cycles, LSB nibble first. A registered carry links the nibbles. Valid/ready handshakes on the operand and result sides let it sit between a register file and a result bus in small datapaths where a full-width adder costs too much area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB (localparam), WIDTH/4, nibble iterations per operation
CNT_W (localparam), max(1,$clog2(NIB)), width of the nibble counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
c_in  in  1  carry into nibble 0
sub  in  1  subtract request; present only with SERIAL_ADDER_SUB_EN
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  registered result
c_out  out  1  carry out of the top nibble

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, counter=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b and c_in into the operand shift regs and carry reg, clear the counter, go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0. Each cycle:
    - feed the low nibble of A, the low nibble of B and the carry reg to the slice;
    - shift the slice's 4-bit sum into the top of the sum shift reg, which shifts right by 4;
    - shift A and B right by 4;
    - carry reg <= slice carry;
    - increment the counter.
  - RUN exit: when counter==NIB-1, go to DONE, set out_valid=1 and c_out=slice carry in the same edge.
  - DONE: out_valid=1; sum and c_out are held stable. On out_valid&out_ready, clear out_valid and go to IDLE. sum and c_out keep their values until the next result is written.
- Latency: out_valid rises exactly NIB edges after the accepting edge. Throughput: one operation per NIB+2 cycles minimum, because in_ready returns the cycle after the result handshake.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1). No saturation.
- Backpressure: out_ready may be low for any duration; DONE holds with outputs unchanged.
- Ignored inputs: in_valid outside IDLE is ignored (no capture, no error). Input changes during RUN have no effect.
- WIDTH=4: NIB=1. The block is in RUN for one cycle, then DONE.
- Reset mid-operation: rst_n low in any state immediately forces the reset values. The partial result is discarded and no out_valid is emitted.

Optional Feature:
SERIAL_ADDER_SUB_EN.
- Defined: the sub port exists. sub is captured with the operands. When sub=1:
  - the B operand reg loads ~b;
  - the carry reg loads 1, and c_in is ignored.
  - Result: sum = a - b. c_out=1 means no borrow.
- Undefined: the sub port is absent and the block only adds.

Decomposition:
- Package serial_adder_pkg:
  - NIB_W=4;
  - state typedef enum {IDLE,RUN,DONE}.
- One sub-module, nibble_adder_slice: combinational 4-bit ripple adder with a true chained carry; inputs a[3:0], b[3:0], ci; outputs s[3:0], co. The controller instantiates it once.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x1111, c_in=0 -> sum=0x2345, c_out=0, out_valid exactly 4 edges after accept.
2. a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; checks carry propagation through all 4 nibbles.
3. a=0x00FF, b=0x0000, c_in=1 -> sum=0x0100, c_out=0; in_valid toggled during RUN produces no second capture.
4. Result 0xABCD ready, out_ready held low 5 cycles -> out_valid, sum and c_out stable all 5 cycles; in_ready=0 throughout; in_ready=1 the cycle after the handshake.
5. rst_n pulsed low during the 2nd RUN cycle -> all outputs at reset values immediately, no out_valid. A following op 0x0001+0x0002 yields 0x0003.
6. (SUB_EN) a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, c_out=1.
